// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adder_tree_pkg
// Brief    : Shared state encoding, default sizes and width helper for the
//            time-multiplexed adder tree sequencer.
// Revision : 1.0
// ============================================================================
package adder_tree_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DATA_W_DEF     = 16;
  localparam int N_OPERANDS_DEF = 32;

  // Each tree level adds one carry bit to the running total.
  function automatic int calc_sum_w(input int data_w, input int n_operands);
    return data_w + $clog2(n_operands);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tree_pair_adder.sv
`default_nettype none
// ============================================================================
// Module   : tree_pair_adder
// Brief    : Unsigned W-bit pair adder with a carry-extended W+1-bit result.
// Revision : 1.0
// ============================================================================
module tree_pair_adder
  import adder_tree_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/adder_tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_sequencer
// Brief    : Reduces a stream of N unsigned operands to their full-width sum
//            using a single pair adder over an in-place scratch buffer.
// Revision : 1.0
// ============================================================================
module adder_tree_sequencer
  import adder_tree_pkg::*;
#(
  parameter  int N_OPERANDS = N_OPERANDS_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  localparam int LEVELS     = $clog2(N_OPERANDS),
  localparam int SUM_W      = calc_sum_w(DATA_W, N_OPERANDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic              busy,
  output logic [2:0]        level
);

  localparam int ADD_W = SUM_W - 1;
  localparam int IDX_W = (LEVELS > 1) ? LEVELS - 1 : 1;
  localparam int BUF_N = N_OPERANDS / 2;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEVELS-1:0]  r_opcnt;
  logic [IDX_W-1:0]   r_pair;
  logic [DATA_W-1:0]  r_pair_reg;
  logic [SUM_W-1:0]   r_buf [BUF_N];
  logic [2:0]         r_level;
  logic               r_out_valid;

  logic               w_flush;
  logic               w_xfer;
  logic               w_last_op;
  logic               w_pair_last;
  logic               w_final;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_pair_max;
  logic [IDX_W-1:0]   w_rd_a;
  logic [IDX_W-1:0]   w_rd_b;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [ADD_W-1:0]   w_add_a;
  logic [ADD_W-1:0]   w_add_b;
  logic [SUM_W-1:0]   w_add_sum;

  assign in_ready  = (r_state == LOAD);
  assign out_valid = r_out_valid;
  assign out_sum   = r_buf[0];
  assign busy      = (r_state != IDLE);
  assign level     = r_level;

  assign w_flush     = flush && (r_state != IDLE);
  assign w_xfer      = in_valid && in_ready && !flush;
  assign w_last_op   = w_xfer && (r_opcnt == LEVELS'(N_OPERANDS - 1));
  // Entries at level L are produced from N >> (L-1) entries of the level below.
  assign w_pair_max  = IDX_W'((N_OPERANDS >> r_level) - 1);
  assign w_pair_last = (r_pair == w_pair_max);
  assign w_final     = (r_state == REDUCE) && w_pair_last && (r_level == 3'(LEVELS));
  assign w_rd_a      = IDX_W'({r_pair, 1'b0});
  assign w_rd_b      = IDX_W'({r_pair, 1'b1});

  // The single adder serves both the level-1 pair sums and the later levels.
  always_comb begin
    w_add_a = ADD_W'(r_pair_reg);
    w_add_b = ADD_W'(in_data);
    if (r_state == REDUCE) begin
      w_add_a = r_buf[w_rd_a][ADD_W-1:0];
      w_add_b = r_buf[w_rd_b][ADD_W-1:0];
    end
  end

  tree_pair_adder #(
    .W (ADD_W)
  ) u_pair_adder (
    .a   (w_add_a),
    .b   (w_add_b),
    .sum (w_add_sum)
  );

  assign w_wr_en  = (w_xfer && r_opcnt[0]) || ((r_state == REDUCE) && !flush);
  assign w_wr_idx = (r_state == REDUCE) ? r_pair : IDX_W'(r_opcnt >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = LOAD;
      LOAD:    if (w_last_op) w_state_nxt = (LEVELS == 1) ? DONE : REDUCE;
      REDUCE:  if (w_final) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
    if (w_flush) begin
      w_state_nxt = LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcnt     <= '0;
      r_pair      <= '0;
      r_pair_reg  <= '0;
      r_level     <= 3'd0;
      r_out_valid <= 1'b0;
    end else if (w_flush) begin
      r_opcnt     <= '0;
      r_pair      <= '0;
      r_pair_reg  <= '0;
      r_level     <= 3'd1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_level <= 3'd1;
        end
        LOAD: begin
          if (w_xfer) begin
            if (!r_opcnt[0]) begin
              r_pair_reg <= in_data;
            end
            // Wraps to zero on the N-th transfer.
            r_opcnt <= r_opcnt + 1'b1;
            if (w_last_op) begin
              if (LEVELS == 1) begin
                r_out_valid <= 1'b1;
              end else begin
                r_level <= 3'd2;
              end
            end
          end
        end
        REDUCE: begin
          if (w_pair_last) begin
            r_pair <= '0;
            if (w_final) begin
              r_out_valid <= 1'b1;
            end else begin
              r_level <= r_level + 3'd1;
            end
          end else begin
            r_pair <= r_pair + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_level     <= 3'd1;
            r_opcnt     <= '0;
            r_pair      <= '0;
            r_pair_reg  <= '0;
          end
        end
        default: begin
          r_level <= 3'd0;
        end
      endcase
    end
  end

  // In-place reduction is safe: write index i never exceeds read index 2i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BUF_N; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_buf[w_wr_idx] <= w_add_sum;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_sequencer
// Brief    : Self-checking bench for adder_tree_sequencer (N=32 and N=2 builds).
// Revision : 1.0
// ============================================================================
module tb_adder_tree_sequencer;

  localparam int N       = 32;
  localparam int DW      = 16;
  localparam int SW      = 21;
  localparam int RED_CYC = N / 2 - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          busy;
  logic [2:0]    level;

  logic          flush2;
  logic          in_valid2;
  logic          in_ready2;
  logic [DW-1:0] in_data2;
  logic          out_valid2;
  logic          out_ready2;
  logic [DW:0]   out_sum2;
  logic          busy2;
  logic [2:0]    level2;

  adder_tree_sequencer #(.N_OPERANDS(N), .DATA_W(DW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .level(level)
  );

  adder_tree_sequencer #(.N_OPERANDS(2), .DATA_W(DW)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
    .busy(busy2), .level(level2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    int            kind;     // 0 const, 1 val*k ramp, 2 val on even k else 0
    logic [DW-1:0] val;
    int            gap;      // in_valid dropped before every gap-th operand
    logic [SW-1:0] exp_sum;
  } vec_t;

  typedef struct {
    string         name;
    logic [SW-1:0] sum;
    int unsigned   t_last;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   exp_sum;
  } v2_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] opnd(input vec_t v, input int k);
    case (v.kind)
      1:       return DW'(k) * v.val;
      2:       return (k % 2 == 0) ? v.val : '0;
      default: return v.val;
    endcase
  endfunction

  function automatic int exp_level(input int j);
    int acc = 0;
    for (int lv = 2; lv <= 5; lv++) begin
      if (j < acc + (N >> lv)) return lv;
      acc += N >> lv;
    end
    return 0;
  endfunction

  task automatic drive_op(input logic [DW-1:0] d, output bit ok);
    int w = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input string nm, input vec_t v, input bit push);
    bit   ok;
    int   to = 0;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (v.gap > 0 && (k % v.gap) == v.gap - 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      drive_op(opnd(v, k), ok);
      if (!ok) to++;
    end
    chk({nm, "_load_stall"}, to, 0);
    if (push) begin
      e.name   = nm;
      e.sum    = v.exp_sum;
      e.t_last = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic watch_reduce(input string nm);
    int bad_ir = 0;
    int bad_lv = 0;
    for (int j = 0; j < RED_CYC; j++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad_ir++;
      if (level !== 3'(exp_level(j))) bad_lv++;
      @(negedge clk);
    end
    chk({nm, "_reduce_ready_low"}, bad_ir, 0);
    chk({nm, "_reduce_levels"}, bad_lv, 0);
  endtask

  task automatic drain(input string nm);
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_drained"}, sb.size(), 0);
  endtask

  // Output monitor: latency on the rising edge of out_valid, sum on handshake.
  bit prev_ov = 1'b0;
  bit prev_hs = 1'b0;
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("out_valid_one_cycle", out_valid, 0);
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_result", sb.size(), 1);
        else chk({sb[0].name, "_latency"}, cyc - sb[0].t_last, RED_CYC);
      end
      if (out_valid && out_ready && !flush) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({e.name, "_sum"}, out_sum, e.sum);
        end
        prev_hs = 1'b1;
      end else begin
        prev_hs = 1'b0;
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  v2_t  v2[2];

  initial begin
    vec_t          sv;
    bit            ok;
    int            bad;
    int            w;
    int            to2;
    logic [SW-1:0] cap;

    vecs[0] = '{name:"ones_ffff",  kind:0, val:16'hFFFF, gap:0, exp_sum:21'd2097120};
    vecs[1] = '{name:"ramp_gap3",  kind:1, val:16'd1,    gap:3, exp_sum:21'd496};
    vecs[2] = '{name:"zeros",      kind:0, val:16'd0,    gap:0, exp_sum:21'd0};
    vecs[3] = '{name:"alt_ffff",   kind:2, val:16'hFFFF, gap:0, exp_sum:21'd1048560};
    vecs[4] = '{name:"const_8000", kind:0, val:16'h8000, gap:2, exp_sum:21'd1048576};
    vecs[5] = '{name:"ramp_x800",  kind:1, val:16'h0800, gap:0, exp_sum:21'd1015808};
    v2[0]   = '{a:16'hFFFF, b:16'h0001, exp_sum:17'h10000};
    v2[1]   = '{a:16'h1234, b:16'h0FF0, exp_sum:17'h02224};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_level", level, 1);
    chk("post_reset_busy", busy, 1);

    for (int i = 0; i < 6; i++) begin
      send_stream(vecs[i].name, vecs[i], 1'b1);
      watch_reduce(vecs[i].name);
      drain(vecs[i].name);
    end

    // Result held while the consumer stalls.
    out_ready = 1'b0;
    sv = '{name:"stall", kind:1, val:16'd3, gap:0, exp_sum:21'd1488};
    send_stream(sv.name, sv, 1'b1);
    watch_reduce(sv.name);
    cap = out_sum;
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      if (out_valid !== 1'b1 || out_sum !== cap || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    chk("stall_captured_sum", cap, 21'd1488);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_load_ready", in_ready, 1);
    chk("stall_valid_dropped", out_valid, 0);
    drain("stall");

    // Abort a partial stream; the operand in the flush cycle is discarded.
    for (int k = 0; k < 10; k++) drive_op(16'd7, ok);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_level", level, 1);
    chk("flush_out_valid", out_valid, 0);
    sv = '{name:"after_flush", kind:0, val:16'd1, gap:0, exp_sum:21'd32};
    send_stream(sv.name, sv, 1'b1);
    watch_reduce(sv.name);
    drain(sv.name);

    // Asynchronous reset in the middle of level 3.
    sv = '{name:"rst_pre", kind:0, val:16'd5, gap:0, exp_sum:21'd160};
    send_stream(sv.name, sv, 1'b0);
    w = 0;
    while (level !== 3'd3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst_reach_level3", level, 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_in_ready", in_ready, 0);
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_sum", out_sum, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_level", level, 0);
    @(negedge clk);
    rst = 1'b0;
    sv = '{name:"after_rst", kind:0, val:16'd2, gap:0, exp_sum:21'd64};
    send_stream(sv.name, sv, 1'b1);
    watch_reduce(sv.name);
    drain(sv.name);

    // N_OPERANDS=2 build: result the cycle after the second transfer.
    to2 = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid2 = 1'b1;
      in_data2  = v2[i].a;
      w = 0;
      while (!in_ready2 && w < 50) begin @(negedge clk); w++; end
      if (!in_ready2) to2++;
      @(negedge clk);
      in_data2 = v2[i].b;
      chk("n2_no_early_valid", out_valid2, 0);
      @(negedge clk);
      in_valid2 = 1'b0;
      chk("n2_valid_next_cycle", out_valid2, 1);
      chk("n2_sum", out_sum2, v2[i].exp_sum);
      @(negedge clk);
      chk("n2_valid_one_cycle", out_valid2, 0);
      chk("n2_ready_again", in_ready2, 1);
    end
    chk("n2_load_stall", to2, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
